// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for the product accumulator slice.
// Default widths match the 32x32 Booth multiplier's 64-bit product.
package product_accumulator_pkg;

  localparam int unsigned PROD_W_DEF = 64;
  localparam int unsigned ACC_W_DEF  = 72;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Signed add overflow from the sign bits alone: operands agree, result disagrees.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Input product stream and output group-result handshake for product_accumulator.
interface product_accumulator_if #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned ACC_W  = 72,
  parameter int unsigned CNT_W  = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_overflow
  );

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_overflow
  );

endinterface

// File: rtl/product_accumulator_acc_adder_sat.sv
// Combinational ACC_W signed adder with overflow flag.
// Clamping to the signed range is built only with PRODUCT_ACC_SATURATE_EN.
module acc_adder_sat
  import product_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = 72
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw;

  always_comb begin
    raw = a + b;
    ovf = add_ovf(a[ACC_W-1], b[ACC_W-1], raw[ACC_W-1]);
`ifdef PRODUCT_ACC_SATURATE_EN
    if (ovf) begin
      // On overflow both operands share a sign, so a's sign picks the rail.
      sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a stream of signed products per group and presents sum/count/overflow on a
// registered result handshake. Optional clamp: define PRODUCT_ACC_SATURATE_EN.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;

  logic             oval_q, oval_nx;
  logic [ACC_W-1:0] oacc_q, oacc_nx;
  logic [CNT_W-1:0] ocnt_q, ocnt_nx;
  logic             oovf_q, oovf_nx;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             sum_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign prod_ext = ACC_W'($signed(bus.in_product));
  assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

  acc_adder_sat #(.ACC_W(ACC_W)) u_adder (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  // in_ready depends on state only, so out_ready never reaches it combinationally.
  assign bus.in_ready = (state == ACCUM);
  assign accept       = bus.in_valid && (state == ACCUM);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    oval_nx  = oval_q;
    oacc_nx  = oacc_q;
    ocnt_nx  = ocnt_q;
    oovf_nx  = oovf_q;
    case (state)
      ACCUM: begin
        if (accept) begin
          if (bus.in_last) begin
            oacc_nx  = sum;
            ocnt_nx  = cnt_inc;
            oovf_nx  = ovf | sum_ovf;
            oval_nx  = 1'b1;
            acc_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
            state_nx = HOLD;
          end else begin
            acc_nx = sum;
            cnt_nx = cnt_inc;
            ovf_nx = ovf | sum_ovf;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          oval_nx  = 1'b0;
          state_nx = ACCUM;
        end
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACCUM;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      oval_q <= 1'b0;
      oacc_q <= '0;
      ocnt_q <= '0;
      oovf_q <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      ovf    <= ovf_nx;
      oval_q <= oval_nx;
      oacc_q <= oacc_nx;
      ocnt_q <= ocnt_nx;
      oovf_q <= oovf_nx;
    end
  end

  assign bus.out_valid    = oval_q;
  assign bus.out_acc      = oacc_q;
  assign bus.out_count    = ocnt_q;
  assign bus.out_overflow = oovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Three product_accumulator configurations (72/8, 64/8, 72/2) share one stimulus
// stream and are checked against an exact-arithmetic group model.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv  = 1'b0;
  logic        il  = 1'b0;
  logic        ordy = 1'b0;
  logic [63:0] ip  = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) if0 ();
  product_accumulator_if #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) if1 ();
  product_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(2)) if2 ();

  assign if0.in_valid = iv; assign if0.in_product = ip; assign if0.in_last = il; assign if0.out_ready = ordy;
  assign if1.in_valid = iv; assign if1.in_product = ip; assign if1.in_last = il; assign if1.out_ready = ordy;
  assign if2.in_valid = iv; assign if2.in_product = ip; assign if2.in_last = il; assign if2.out_ready = ordy;

  product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
  product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1));
  product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact signed sum over the group, reduced to aw bits on each overflowing add.
  function automatic void model(input longint q[$], input int aw, input int cw,
                                output logic [127:0] acc, output logic [127:0] cnt,
                                output logic [127:0] ovf);
    logic signed [127:0] a, s, m, hi, lo;
    int unsigned cmax;
    m  = 128'sd1 <<< aw;
    hi = (m >>> 1) - 128'sd1;
    lo = -(m >>> 1);
    a  = '0;
    ovf = '0;
    foreach (q[i]) begin
      s = a + q[i];
      if (s > hi || s < lo) begin
        ovf = 128'd1;
`ifdef PRODUCT_ACC_SATURATE_EN
        s = (s > hi) ? hi : lo;
`else
        s = s & (m - 128'sd1);
        if (s > hi) s = s - m;
`endif
      end
      a = s;
    end
    acc  = a & (m - 128'sd1);
    cmax = (32'd1 << cw) - 32'd1;
    cnt  = (q.size() > cmax) ? 128'(cmax) : 128'(q.size());
  endfunction

  task automatic check_outputs(input string tag, input longint q[$]);
    logic [127:0] ea, ec, eo;
    model(q, 72, 8, ea, ec, eo);
    chk({tag, ".acc0"}, 128'(if0.out_acc), ea);
    chk({tag, ".cnt0"}, 128'(if0.out_count), ec);
    chk({tag, ".ovf0"}, 128'(if0.out_overflow), eo);
    model(q, 64, 8, ea, ec, eo);
    chk({tag, ".acc1"}, 128'(if1.out_acc), ea);
    chk({tag, ".cnt1"}, 128'(if1.out_count), ec);
    chk({tag, ".ovf1"}, 128'(if1.out_overflow), eo);
    model(q, 72, 2, ea, ec, eo);
    chk({tag, ".acc2"}, 128'(if2.out_acc), ea);
    chk({tag, ".cnt2"}, 128'(if2.out_count), ec);
    chk({tag, ".ovf2"}, 128'(if2.out_overflow), eo);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".valid"}, 128'({if0.out_valid, if1.out_valid, if2.out_valid}), 128'd0);
    chk({tag, ".ready"}, 128'({if0.in_ready, if1.in_ready, if2.in_ready}), 128'd7);
    chk({tag, ".acc"}, 128'(if0.out_acc | if2.out_acc) | 128'(if1.out_acc), 128'd0);
    chk({tag, ".cnt"}, 128'(if0.out_count | if1.out_count) | 128'(if2.out_count), 128'd0);
    chk({tag, ".ovf"}, 128'({if0.out_overflow, if1.out_overflow, if2.out_overflow}), 128'd0);
  endtask

  // Sends one group, optionally stalls the result, optionally leaves beat 7 pending.
  task automatic run_group(input string tag, input longint q[$], input int hold, input bit gaps,
                           input bit next7);
    int n;
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        iv = 1'b0;
        step();
      end
      iv = 1'b1;
      ip = q[i];
      il = (i == q.size() - 1);
      n = 0;
      while (!if0.in_ready && n < 20) begin
        step();
        n++;
      end
      if (n == 20) chk({tag, ".ready_timeout"}, 128'(if0.in_ready), 128'd1);
      step();
    end
    iv = 1'b0;
    il = 1'b0;
    ordy = (hold == 0);
    chk({tag, ".valid"}, 128'({if0.out_valid, if1.out_valid, if2.out_valid}), 128'd7);
    chk({tag, ".busy"}, 128'({if0.in_ready, if1.in_ready, if2.in_ready}), 128'd0);
    check_outputs(tag, q);
    if (next7) begin
      iv = 1'b1;
      ip = 64'd7;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, ".hvalid"}, 128'({if0.out_valid, if1.out_valid, if2.out_valid}), 128'd7);
      chk({tag, ".hbusy"}, 128'({if0.in_ready, if1.in_ready, if2.in_ready}), 128'd0);
      check_outputs({tag, ".hold"}, q);
    end
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    chk({tag, ".drop"}, 128'({if0.out_valid, if1.out_valid, if2.out_valid}), 128'd0);
    chk({tag, ".reopen"}, 128'({if0.in_ready, if1.in_ready, if2.in_ready}), 128'd7);
  endtask

  initial begin
    longint q[$];

    repeat (3) step();
    rst = 1'b0;
    check_idle("reset");

    run_group("basic", '{64'sd5, -64'sd3, 64'sd10}, 0, 1'b0, 1'b0);
    run_group("neg1", '{-64'sd1}, 4, 1'b0, 1'b1);
    run_group("after_hold", '{64'sd7, 64'sd2}, 1, 1'b0, 1'b0);
    run_group("maxpos", '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sd1}, 0, 1'b0, 1'b0);
    run_group("minneg", '{64'sh8000_0000_0000_0000, -64'sd1, -64'sd5}, 2, 1'b0, 1'b0);
    run_group("sat_back", '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF,
                            64'sh8000_0000_0000_0000}, 0, 1'b0, 1'b0);
    run_group("six_ones", '{1, 1, 1, 1, 1, 1}, 0, 1'b1, 1'b0);

    // Reset mid-group discards the partial sum.
    iv = 1'b1; ip = 64'd100; il = 1'b0;
    step();
    step();
    iv = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_mid");
    run_group("post_rst", '{64'sd1}, 0, 1'b0, 1'b0);

    // Reset while a result is pending discards it.
    iv = 1'b1; ip = 64'd55; il = 1'b1;
    step();
    iv = 1'b0; il = 1'b0;
    chk("rst_hold.pre", 128'(if0.out_valid), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_hold");

    for (int g = 0; g < 16; g++) begin
      int len;
      len = $urandom_range(1, 6);
      q.delete();
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(2))
          0: q.push_back(longint'($urandom_range(200)) - 100);
          1: q.push_back({$urandom, $urandom});
          default: q.push_back($urandom_range(1) ? 64'sh7FFF_FFFF_FFFF_FFF0 : 64'sh8000_0000_0000_0010);
        endcase
      end
      run_group($sformatf("rand%0d", g), q, $urandom_range(3), 1'b1, 1'b0);
    end

    q.delete();
    for (int b = 0; b < 260; b++) q.push_back({$urandom, $urandom});
    run_group("long260", q, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
